display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the four-digit seven-segment display. It shares one BCD-to-7-segment encoder across four digit positions by presenting one BCD digit at a time with its valid strobe `Vs`, and it drives the active-low digit enables in step. New display values are double-buffered and committed only at frame boundaries, so a displayed number never tears. The block sits between the counter/clock logic that produces the BCD digits and the encoder/display pins.

---
 rtl/display_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: time-multiplexes one shared BCD encoder,
// double-buffers display values and commits them only at frame boundaries.
module display_scan_ctrl #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic        Vs,
  output logic [3:0]  digit_sel,
  output logic        ack
);

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] ON_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {IDLE, ON, BLANK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   stage_q, stage_d;
  logic          pending_q, pending_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          vs_q, vs_d;
  logic [3:0]    sel_q, sel_d;
  logic          ack_q, ack_d;

  logic          commit_pt;
  logic [15:0]   upper;
  logic          lz_blank;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= 16'h0000;
      stage_q   <= 16'h0000;
      pending_q <= 1'b0;
      bcd_q     <= 4'h0;
      vs_q      <= 1'b0;
      sel_q     <= 4'b1111;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      stage_q   <= stage_d;
      pending_q <= pending_d;
      bcd_q     <= bcd_d;
      vs_q      <= vs_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ON;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
        ON: begin
          if (cnt_q == ON_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BLANK: begin
          if (cnt_q == BLK_LAST) begin
            state_d = ON;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // A load landing on a commit point bypasses staging so only one ack is issued.
  assign commit_pt = (state_q == IDLE) ||
                     ((state_q == BLANK) && (idx_q == 2'd3) && (cnt_q == BLK_LAST));

  always_comb begin
    shadow_d  = shadow_q;
    stage_d   = stage_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    if (commit_pt) begin
      if (load) begin
        shadow_d  = digits_in;
        stage_d   = digits_in;
        pending_d = 1'b0;
        ack_d     = 1'b1;
      end else if (pending_q) begin
        shadow_d  = stage_q;
        pending_d = 1'b0;
        ack_d     = 1'b1;
      end
    end else if (load) begin
      stage_d   = digits_in;
      pending_d = 1'b1;
    end
  end

  // Digit idx and everything above it shifted down; all-zero means a leading zero.
  assign upper    = shadow_q >> {idx_q, 2'b00};
  assign lz_blank = blank_lz && (idx_q != 2'd0) && (upper == 16'h0000);

  always_comb begin
    bcd_d = upper[3:0];
    sel_d = 4'b1111;
    vs_d  = 1'b0;
    if ((state_q == ON) && !lz_blank) begin
      sel_d = ~(4'b0001 << idx_q);
      vs_d  = 1'b1;
    end
  end

  assign bcd       = bcd_q;
  assign Vs        = vs_q;
  assign digit_sel = sel_q;
  assign ack       = ack_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIV=4, BLANK_CYC=2 (6-cycle slots, 24-cycle frames).
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic        Vs;
  logic [3:0]  digit_sel;
  logic        ack;

  int n_assert = 0;
  int n_fail   = 0;

  display_scan_ctrl #(.DIV(4), .BLANK_CYC(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .load      (load),
    .digits_in (digits_in),
    .blank_lz  (blank_lz),
    .bcd       (bcd),
    .Vs        (Vs),
    .digit_sel (digit_sel),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One digit slot: 4 ON cycles then 2 dark cycles. Optional load applied before tick ld_tick.
  task automatic slot(input string tag, input logic [3:0] esel, input logic [3:0] ebcd,
                      input logic evs, input logic eack_last, input int ld_tick,
                      input logic [15:0] ld_val);
    for (int j = 0; j < 6; j++) begin
      if (j == ld_tick) begin
        load      = 1'b1;
        digits_in = ld_val;
      end
      tick();
      load = 1'b0;
      if (j < 4) begin
        chk({tag, "_sel"}, {12'h0, digit_sel}, {12'h0, esel});
        chk({tag, "_bcd"}, {12'h0, bcd}, {12'h0, ebcd});
        chk({tag, "_vs"}, {15'h0, Vs}, {15'h0, evs});
      end else begin
        chk({tag, "_blk_sel"}, {12'h0, digit_sel}, 16'h000f);
        chk({tag, "_blk_vs"}, {15'h0, Vs}, 16'h0000);
      end
      chk({tag, "_ack"}, {15'h0, ack}, {15'h0, (j == 5) ? eack_last : 1'b0});
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    en        = 1'b1;
    load      = 1'b0;
    digits_in = 16'h0000;
    blank_lz  = 1'b0;
    tick();
    tick();
    chk("rst_bcd", {12'h0, bcd}, 16'h0000);
    chk("rst_sel", {12'h0, digit_sel}, 16'h000f);
    chk("rst_vs", {15'h0, Vs}, 16'h0000);
    chk("rst_ack", {15'h0, ack}, 16'h0000);

    // Release with en=1 and a load sampled in the single IDLE cycle.
    reset_n   = 1'b1;
    load      = 1'b1;
    digits_in = 16'h1234;
    tick();
    load = 1'b0;
    chk("idle_ack", {15'h0, ack}, 16'h0001);
    chk("idle_sel", {12'h0, digit_sel}, 16'h000f);
    chk("idle_vs", {15'h0, Vs}, 16'h0000);

    // Frame 1: 1234
    slot("f1d0", 4'b1110, 4'h4, 1'b1, 1'b0, -1, 16'h0);
    slot("f1d1", 4'b1101, 4'h3, 1'b1, 1'b0, -1, 16'h0);
    slot("f1d2", 4'b1011, 4'h2, 1'b1, 1'b0, -1, 16'h0);
    slot("f1d3", 4'b0111, 4'h1, 1'b1, 1'b0, -1, 16'h0);

    // Frame 2: load 0567 at digit 1, old value finishes, ack at wrap
    slot("f2d0", 4'b1110, 4'h4, 1'b1, 1'b0, -1, 16'h0);
    slot("f2d1", 4'b1101, 4'h3, 1'b1, 1'b0, 0, 16'h0567);
    slot("f2d2", 4'b1011, 4'h2, 1'b1, 1'b0, -1, 16'h0);
    slot("f2d3", 4'b0111, 4'h1, 1'b1, 1'b1, -1, 16'h0);

    // Frame 3: 0567 without blanking; stage 0007
    slot("f3d0", 4'b1110, 4'h7, 1'b1, 1'b0, 0, 16'h0007);
    slot("f3d1", 4'b1101, 4'h6, 1'b1, 1'b0, -1, 16'h0);
    slot("f3d2", 4'b1011, 4'h5, 1'b1, 1'b0, -1, 16'h0);
    slot("f3d3", 4'b0111, 4'h0, 1'b1, 1'b1, -1, 16'h0);

    // Frame 4: 0007 with leading-zero blanking; stage 0000
    blank_lz = 1'b1;
    slot("f4d0", 4'b1110, 4'h7, 1'b1, 1'b0, 0, 16'h0000);
    slot("f4d1", 4'b1111, 4'h0, 1'b0, 1'b0, -1, 16'h0);
    slot("f4d2", 4'b1111, 4'h0, 1'b0, 1'b0, -1, 16'h0);
    slot("f4d3", 4'b1111, 4'h0, 1'b0, 1'b1, -1, 16'h0);

    // Frame 5: 0000 lights only digit 0
    slot("f5d0", 4'b1110, 4'h0, 1'b1, 1'b0, -1, 16'h0);
    slot("f5d1", 4'b1111, 4'h0, 1'b0, 1'b0, -1, 16'h0);
    slot("f5d2", 4'b1111, 4'h0, 1'b0, 1'b0, -1, 16'h0);
    slot("f5d3", 4'b1111, 4'h0, 1'b0, 1'b0, -1, 16'h0);

    // Frame 6: two loads in one frame, one ack
    blank_lz = 1'b0;
    slot("f6d0", 4'b1110, 4'h0, 1'b1, 1'b0, 0, 16'h1111);
    slot("f6d1", 4'b1101, 4'h0, 1'b1, 1'b0, -1, 16'h0);
    slot("f6d2", 4'b1011, 4'h0, 1'b1, 1'b0, 0, 16'h2222);
    slot("f6d3", 4'b0111, 4'h0, 1'b1, 1'b1, -1, 16'h0);

    // Frame 7: 2222; load 4321 exactly on the wrap cycle
    slot("f7d0", 4'b1110, 4'h2, 1'b1, 1'b0, -1, 16'h0);
    slot("f7d1", 4'b1101, 4'h2, 1'b1, 1'b0, -1, 16'h0);
    slot("f7d2", 4'b1011, 4'h2, 1'b1, 1'b0, -1, 16'h0);
    slot("f7d3", 4'b0111, 4'h2, 1'b1, 1'b1, 5, 16'h4321);

    // Frame 8: 4321 right away; drop en during digit 2
    slot("f8d0", 4'b1110, 4'h1, 1'b1, 1'b0, -1, 16'h0);
    slot("f8d1", 4'b1101, 4'h2, 1'b1, 1'b0, -1, 16'h0);
    tick();
    chk("en_d2_sel", {12'h0, digit_sel}, 16'h000b);
    chk("en_d2_bcd", {12'h0, bcd}, 16'h0003);
    en = 1'b0;
    tick();
    chk("en_off_lag_sel", {12'h0, digit_sel}, 16'h000b);
    tick();
    chk("en_off_sel", {12'h0, digit_sel}, 16'h000f);
    chk("en_off_vs", {15'h0, Vs}, 16'h0000);
    tick();
    chk("en_idle_sel", {12'h0, digit_sel}, 16'h000f);
    chk("en_idle_ack", {15'h0, ack}, 16'h0000);
    en = 1'b1;
    tick();
    chk("en_re_sel", {12'h0, digit_sel}, 16'h000f);
    slot("re_d0", 4'b1110, 4'h1, 1'b1, 1'b0, -1, 16'h0);
    tick();
    chk("pre_rst_sel", {12'h0, digit_sel}, 16'h000d);
    chk("pre_rst_bcd", {12'h0, bcd}, 16'h0002);

    // Asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_bcd", {12'h0, bcd}, 16'h0000);
    chk("arst_sel", {12'h0, digit_sel}, 16'h000f);
    chk("arst_vs", {15'h0, Vs}, 16'h0000);
    chk("arst_ack", {15'h0, ack}, 16'h0000);
    #2;
    reset_n = 1'b1;
    tick();
    chk("post_idle_sel", {12'h0, digit_sel}, 16'h000f);
    chk("post_idle_ack", {15'h0, ack}, 16'h0000);
    slot("post_d0", 4'b1110, 4'h0, 1'b1, 1'b0, -1, 16'h0);
    slot("post_d1", 4'b1101, 4'h0, 1'b1, 1'b0, -1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
